image_receiver: RTL



---
 rtl/image_link_pkg.sv | 26 ++
 rtl/image_receiver_if.sv | 20 ++
 rtl/uart_rx_byte.sv | 87 ++++++++
 rtl/image_receiver.sv | 131 +++++++++++++
 4 files changed

// File: rtl/image_link_pkg.sv
// Shared definitions for the robot image link (sender and receiver sides).
// Frame = SOF marker pixel followed by NUM_PIXELS pixels, two bytes per pixel.
package image_link_pkg;

   localparam logic [11:0] SOF_MARKER     = 12'h00A;
   localparam int          NUM_PIXELS_DEF = 320 * 240;
   localparam int          BAUD_RATE_DEF  = 115200;
   localparam int          ADDR_W         = 17;
   localparam int          PIX_W          = 12;

   typedef enum logic {
      WAIT_SOF  = 1'b0,
      RECEIVING = 1'b1
   } frame_state_t;

   typedef enum logic {
      PH_HI = 1'b0,
      PH_LO = 1'b1
   } byte_phase_t;

   // High byte carries only pixel[11:8]; any bit in the upper nibble is malformed.
   function automatic logic hi_byte_ok(input logic [7:0] b);
      return (b[7:4] == 4'h0);
   endfunction

endpackage

// File: rtl/image_receiver_if.sv
// Frame-buffer write port plus frame status, driven by image_receiver.
interface image_receiver_if;
   import image_link_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_address;
   logic [PIX_W-1:0]  wr_data;
   logic              frame_done;
   logic              frame_error;
   logic              receiving;

   modport master (
      output wr_en, wr_address, wr_data, frame_done, frame_error, receiving
   );

   modport slave (
      input wr_en, wr_address, wr_data, frame_done, frame_error, receiving
   );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start.
// Reusable for any 8N1 link; knows nothing about the image protocol.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       framing_error
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;

   bit_state_t       r_state;
   logic             r_sync1, r_sync2, r_rx_d;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_rx_d        <= 1'b1;
         r_cnt         <= '0;
         r_bit         <= '0;
         r_shift       <= '0;
         byte_valid    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         r_sync1       <= rx;
         r_sync2       <= r_sync1;
         r_rx_d        <= r_sync2;
         byte_valid    <= 1'b0;
         framing_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_rx_d && !r_sync2) begin
                  r_state <= START;
                  r_cnt   <= '0;
               end
            end
            // A low pulse shorter than half a bit is treated as noise.
            START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= r_sync2 ? IDLE : DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt   <= '0;
                  r_shift <= {r_sync2, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            STOP: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  if (r_sync2) byte_valid    <= 1'b1;
                  else         framing_error <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign byte_data = r_shift;

endmodule

// File: rtl/image_receiver.sv
// Image stream receiver: bytes -> RGB444 pixels -> frame-buffer writes after an SOF marker.
// Aborts the frame on framing error, malformed high byte or inter-byte timeout.
module image_receiver
   import image_link_pkg::*;
#(
   parameter int          CLK_FREQ     = 50_000_000,
   parameter int          BAUD_RATE    = BAUD_RATE_DEF,
   parameter int          NUM_PIXELS   = NUM_PIXELS_DEF,
   parameter logic [11:0] SOF_PIXEL    = SOF_MARKER,
   parameter int          TIMEOUT_CLKS = 5_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             uart_in,
   image_receiver_if.master bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int IDLE_W       = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CLKS);

   logic [7:0]       w_byte_data;
   logic             w_byte_valid;
   logic             w_framing_error;
   logic [PIX_W-1:0] w_pixel;
   logic             w_rx;
   logic             w_timeout;

   frame_state_t      r_state;
   byte_phase_t       r_phase;
   logic [3:0]        r_hi;
   logic [ADDR_W-1:0] r_pix_cnt;
   logic [IDLE_W-1:0] r_idle;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [PIX_W-1:0]  r_wr_data;
   logic              r_frame_done;
   logic              r_frame_error;
   logic              r_done_pend;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (uart_in),
      .byte_data     (w_byte_data),
      .byte_valid    (w_byte_valid),
      .framing_error (w_framing_error)
   );

   assign w_pixel   = {r_hi, w_byte_data};
   assign w_rx      = (r_state == RECEIVING);
   assign w_timeout = w_rx && (r_idle == IDLE_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= WAIT_SOF;
         r_phase       <= PH_HI;
         r_hi          <= '0;
         r_pix_cnt     <= '0;
         r_idle        <= '0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_done  <= 1'b0;
         r_frame_error <= 1'b0;
         r_done_pend   <= 1'b0;
      end else begin
         r_wr_en       <= 1'b0;
         r_frame_error <= 1'b0;
         r_frame_done  <= r_done_pend;
         r_done_pend   <= 1'b0;
         // A byte arriving on the timeout cycle wins: the timer simply restarts.
         if (w_byte_valid || !w_rx || w_timeout) r_idle <= '0;
         else                                    r_idle <= r_idle + 1'b1;

         if (w_framing_error) begin
            if (w_rx) begin
               r_frame_error <= 1'b1;
               r_state       <= WAIT_SOF;
               r_phase       <= PH_HI;
               r_pix_cnt     <= '0;
            end
         end else if (w_byte_valid) begin
            if (r_phase == PH_HI) begin
               // A malformed high byte keeps the phase at HI so the next byte resyncs.
               if (hi_byte_ok(w_byte_data)) begin
                  r_hi    <= w_byte_data[3:0];
                  r_phase <= PH_LO;
               end else if (w_rx) begin
                  r_frame_error <= 1'b1;
                  r_state       <= WAIT_SOF;
                  r_pix_cnt     <= '0;
               end
            end else begin
               r_phase <= PH_HI;
               if (!w_rx) begin
                  if (w_pixel == SOF_PIXEL) begin
                     r_state   <= RECEIVING;
                     r_pix_cnt <= '0;
                  end
               end else begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_pix_cnt;
                  r_wr_data <= w_pixel;
                  if (r_pix_cnt == LAST_ADDR) begin
                     r_pix_cnt   <= '0;
                     r_state     <= WAIT_SOF;
                     r_done_pend <= 1'b1;
                  end else begin
                     r_pix_cnt <= r_pix_cnt + 1'b1;
                  end
               end
            end
         end else if (w_timeout) begin
            r_frame_error <= 1'b1;
            r_state       <= WAIT_SOF;
            r_phase       <= PH_HI;
            r_pix_cnt     <= '0;
         end
      end
   end

   assign bus.wr_en       = r_wr_en;
   assign bus.wr_address  = r_wr_addr;
   assign bus.wr_data     = r_wr_data;
   assign bus.frame_done  = r_frame_done;
   assign bus.frame_error = r_frame_error;
   assign bus.receiving   = w_rx;

endmodule
